// File: rtl/div32_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Signed support is enabled by defining DIV32_SIGNED_EN.
package div32_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Sign correction for magnitude divide results (DIV32_SIGNED_EN).
// Quotient truncates toward zero; remainder follows the dividend sign.
module div_sign_fix
  import div32_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] r_i,
  input  logic             a_neg_i,
  input  logic             b_neg_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o
);

  assign q_o = (a_neg_i ^ b_neg_i) ? -q_i : q_i;
  assign r_o = a_neg_i ? -r_i : r_i;

endmodule

// File: rtl/div32x32_fsm.sv
// Sequential restoring divider, one quotient bit per cycle.
// Define DIV32_SIGNED_EN to honour signed_op (two's complement divide).
module div32x32_fsm
  import div32_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic dbz_q, dbz_d;

  logic a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] fix_q, fix_r;
  logic [WIDTH:0] shifted;
  logic lt;

`ifdef DIV32_SIGNED_EN
  logic a_neg_q, b_neg_q;

  assign a_neg = signed_op & dividend[WIDTH-1];
  assign b_neg = signed_op & divisor[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      a_neg_q <= a_neg;
      b_neg_q <= b_neg;
    end
  end

  div_sign_fix #(
    .WIDTH(WIDTH)
  ) u_sign_fix (
    .q_i    (q_q),
    .r_i    (rem_q),
    .a_neg_i(a_neg_q),
    .b_neg_i(b_neg_q),
    .q_o    (fix_q),
    .r_o    (fix_r)
  );
`else
  logic unused_signed;

  assign unused_signed = signed_op;
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
  assign fix_q = q_q;
  assign fix_r = rem_q;
`endif

  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;

  // Partial remainder shifted with the next dividend bit.
  assign shifted = {rem_q, q_q[WIDTH-1]};
  assign lt = shifted < {1'b0, dvsr_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          if (divisor == '0) begin
            quo_d   = '1;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = '0;
            q_d     = a_mag;
            dvsr_d  = b_mag;
            cnt_d   = CW'(WIDTH - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        q_d   = {q_q[WIDTH-2:0], ~lt};
        rem_d = lt ? shifted[WIDTH-1:0]
                   : shifted[WIDTH-1:0] - dvsr_q;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        quo_d   = fix_q;
        rmd_d   = fix_r;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state_q == CALC) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/div32x32_fsm.md
# div32x32_fsm

Sequential 32-bit restoring divider. It is the inverse-operation companion to the 32x32 sequential multiplier and uses the same start/busy control style. A single FSM plus datapath computes one quotient bit per cycle and returns a quotient and a remainder with a fixed latency. It sits beside the multiplier in the arithmetic unit, and the same sequencer drives both.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: launches a divide; sampled only in `IDLE`.
- `signed_op` in 1: signed divide; honoured only when `DIV32_SIGNED_EN` is defined.
- `dividend` in WIDTH: numerator; captured on the accepted `start`.
- `divisor` in WIDTH: denominator; captured on the accepted `start`.
- `busy` out 1: high while a divide is in flight.
- `done` out 1: one-cycle pulse when results are valid.
- `quotient` out WIDTH: registered result, held until the next accepted `start`.
- `remainder` out WIDTH: registered result, held until the next accepted `start`.
- `div_by_zero` out 1: registered flag, valid with `done`, held with the results.

## Operation
- **States:** `IDLE`, `CALC`, `FIX`, `DONE`.
- **IDLE:**
  - `start=1` captures the operands and clears the `div_by_zero` flag.
  - If `divisor==0`, go to `DONE`. Otherwise go to `CALC`, with counter = `WIDTH-1`.
- **CALC, one quotient bit per cycle:**
  - Shift `{rem, q}` left by one.
  - Compute a trial `rem - |divisor|` at `WIDTH+1` bits.
  - If the result is non-negative, keep it and set `q[0]=1`; otherwise restore.
  - Leave `CALC` when counter==0; otherwise decrement the counter.
- **FIX (always one cycle):**
  - Apply sign correction when enabled.
  - Register `quotient` and `remainder`.
  - Go to `DONE`.
- **DONE:** `done=1` and `busy=0` for one cycle, then return to `IDLE`.
- **Divide by zero:**
  - `quotient` = all ones, `remainder` = `dividend`, `div_by_zero=1`.
  - Applies in both signed and unsigned mode.
- **Unsigned mode:** `q = floor(dividend/divisor)`, `r = dividend mod divisor`.
- **`start` while busy:** ignored; the operands are not recaptured.
- **`start` held high:**
  - A new divide is accepted only in `IDLE`.
  - Because `DONE` always passes through `IDLE`, back-to-back operations need `start` to be high in `IDLE`.

## Timing
- **Reset values:** `busy=0`, `done=0`, `quotient=0`, `remainder=0`, `div_by_zero=0`, state `IDLE`.
- **Cycle numbering:** cycle 0 is the `IDLE` cycle in which `start=1` is sampled.
- **Normal divide:**
  - `busy=1` in cycles 1 through `WIDTH+1` (the `CALC` cycles plus `FIX`).
  - `done=1` in cycle `WIDTH+2` (cycle 34 for the default width).
- **Divide by zero:** `done=1` in cycle 1; `busy` stays 0.
- **Latency:** identical with and without the macro.
- **Result stability:** `quotient` and `remainder` change only on the `FIX` edge or the div-by-zero edge. They are stable from `done` until the next `FIX`.
- **Reset mid-operation:** on the next edge all outputs return to their reset values and the in-flight result is discarded; `done` never fires.

## Configuration
- **Macro:** `DIV32_SIGNED_EN`.
- **Defined:**
  - With `signed_op=1`, the operands are treated as two's complement and the magnitudes are divided.
  - In `FIX`, the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign. Quotients truncate toward zero.
  - Overflow case `0x80000000 / 0xFFFFFFFF`: `quotient=0x80000000`, `remainder=0`.
- **Undefined:**
  - `signed_op` is ignored and every divide is unsigned.
  - `FIX` only registers the results.
  - The port remains present.

## Structure
- **Package `div32_pkg`:**
  - `div_state_t` enum (`IDLE`, `CALC`, `FIX`, `DONE`), 2 bits.
  - Constant `DIV_LATENCY = WIDTH+2`.
  - Constant `DIV0_QUOTIENT` = all ones.
- **Sub-module `div_sign_fix`:** combinational. It takes the raw quotient, the raw remainder and the two operand signs and returns the corrected `quotient` and `remainder`. It is instantiated only under `DIV32_SIGNED_EN`.
- **Top module:** holds the FSM, counter, shift/subtract datapath and output registers.

## Test plan
- `100 / 7`, unsigned, `start` in cycle 0:
  - `busy` high in cycles 1–33, `done` in cycle 34.
  - `quotient=14`, `remainder=2`, `div_by_zero=0`.
- `0xFFFFFFFF / 1` and `5 / 9`:
  - first: `quotient=0xFFFFFFFF`, `remainder=0`;
  - second: `quotient=0`, `remainder=5`.
- `0x1234 / 0`:
  - `done` in cycle 1, `busy` never high.
  - `quotient=0xFFFFFFFF`, `remainder=0x1234`, `div_by_zero=1`.
- With the macro and `signed_op=1`:
  - `-7 / 2` gives `quotient=0xFFFFFFFD`, `remainder=0xFFFFFFFF`.
  - `0x80000000 / -1` gives `quotient=0x80000000`, `remainder=0`.
- `start` pulsed with new operands at cycle 10 of a divide: ignored; the original result appears at cycle 34.
- `reset` asserted at cycle 15 of a divide:
  - all outputs are 0 the next cycle and no `done` pulse occurs.
  - A subsequent `20 / 3` returns `quotient=6`, `remainder=2`.
